// File: rtl/pc_unit.sv
// Fetch-stage program counter: picks the next PC from exception, eret, stall,
// redirect (live or buffered) and sequential sources, and decodes the IM index.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_3000,
    parameter int               IM_WORDS   = 4096,
    parameter int               ADDR_BITS  = 12,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_target,
    input  logic                 exc_req,
    input  logic                 eret,
    input  logic [WIDTH-1:0]     epc,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus4,
    output logic [ADDR_BITS-1:0] instr_addr,
    output logic                 fetch_fault,
    output logic                 redirect_pending
);

    // One past the last IM byte, held at WIDTH+1 bits so it cannot wrap.
    localparam logic [WIDTH:0] IM_LIMIT = {1'b0, RESET_ADDR} + (WIDTH+1)'(4 * IM_WORDS);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_v, pend_v_d;
    logic [WIDTH-1:0] pend_tgt, pend_tgt_d;

    function automatic logic addr_fault(input logic [WIDTH-1:0] a);
        logic [WIDTH:0] a_ext;
        a_ext = {1'b0, a};
        return (a[1:0] != 2'b00) || (a_ext < {1'b0, RESET_ADDR}) || (a_ext >= IM_LIMIT);
    endfunction

    function automatic logic [ADDR_BITS-1:0] word_index(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] offset;
        offset = a - RESET_ADDR;
        return ADDR_BITS'(offset >> 2);
    endfunction

    always_comb begin
        pc_d       = pc_q + WIDTH'(4);
        pend_v_d   = pend_v;
        pend_tgt_d = pend_tgt;
        if (exc_req) begin
            pc_d     = EXC_VECTOR;
            pend_v_d = 1'b0;
        end else if (eret) begin
            pc_d     = epc;
            pend_v_d = 1'b0;
        end else if (stall) begin
            // Hold fetch; remember the newest redirect seen during the stall.
            pc_d = pc_q;
            if (redirect_valid) begin
                pend_v_d   = 1'b1;
                pend_tgt_d = redirect_target;
            end
        end else if (redirect_valid) begin
            pc_d     = redirect_target;
            pend_v_d = 1'b0;
        end else if (pend_v) begin
            pc_d     = pend_tgt;
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_ADDR;
            pend_v   <= 1'b0;
            pend_tgt <= '0;
        end else begin
            pc_q     <= pc_d;
            pend_v   <= pend_v_d;
            pend_tgt <= pend_tgt_d;
        end
    end

    always_comb begin
        pc               = pc_q;
        pc_plus4         = pc_q + WIDTH'(4);
        redirect_pending = pend_v;
        fetch_fault      = addr_fault(pc_q);
        instr_addr       = fetch_fault ? '0 : word_index(pc_q);
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit; expected state is queued per cycle and
// checked by an independent monitor on the falling edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, exc_req, eret;
    logic [31:0] redirect_target, epc;
    logic [31:0] pc, pc_plus4;
    logic [11:0] instr_addr;
    logic        fetch_fault, redirect_pending;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [11:0] ia;
        logic        ff;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .pc_plus4(pc_plus4), .instr_addr(instr_addr),
        .fetch_fault(fetch_fault), .redirect_pending(redirect_pending)
    );

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: outputs depend only on registered state, so mid-cycle sampling is stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32({e.name, ".pc"}, pc, e.pc);
                chk32({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
                chk32({e.name, ".instr_addr"}, {20'd0, instr_addr}, {20'd0, e.ia});
                chk32({e.name, ".fetch_fault"}, {31'd0, fetch_fault}, {31'd0, e.ff});
                chk32({e.name, ".pending"}, {31'd0, redirect_pending}, {31'd0, e.pend});
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic s, input logic rv,
                        input logic [31:0] rt, input logic ex, input logic er,
                        input logic [31:0] ep, input logic [31:0] e_pc,
                        input logic [11:0] e_ia, input logic e_ff, input logic e_pend);
        exp_t e;
        reset = r; stall = s; redirect_valid = rv; redirect_target = rt;
        exc_req = ex; eret = er; epc = ep;
        @(posedge clk);
        e.name = nm; e.pc = e_pc; e.ia = e_ia; e.ff = e_ff; e.pend = e_pend;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        exc_req = 1'b0; eret = 1'b0; epc = '0;
        #1;
        //    name        rst stl rv target        exc eret epc            pc            ia       ff pend
        step("reset",     1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 12'h000, 0, 0);
        step("seq1",      0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 12'h001, 0, 0);
        step("seq2",      0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 12'h002, 0, 0);
        step("seq3",      0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_300C, 12'h003, 0, 0);
        step("stall_rd",  0, 1, 1, 32'h3100,      0, 0, 32'h0,         32'h0000_300C, 12'h003, 0, 1);
        step("stall2",    0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_300C, 12'h003, 0, 1);
        step("pend_app",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3100, 12'h040, 0, 0);
        step("after_pd",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3104, 12'h041, 0, 0);
        step("stall_rd2", 0, 1, 1, 32'h3100,      0, 0, 32'h0,         32'h0000_3104, 12'h041, 0, 1);
        step("live_wins", 0, 0, 1, 32'h3200,      0, 0, 32'h0,         32'h0000_3200, 12'h080, 0, 0);
        step("seq4",      0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3204, 12'h081, 0, 0);
        step("stall_rd3", 0, 1, 1, 32'h3300,      0, 0, 32'h0,         32'h0000_3204, 12'h081, 0, 1);
        step("exc_stall", 0, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 12'h460, 0, 0);
        step("exc_eret",  0, 0, 0, 32'h0,         1, 1, 32'h3040,      32'h0000_4180, 12'h460, 0, 0);
        step("eret",      0, 0, 0, 32'h0,         0, 1, 32'h3040,      32'h0000_3040, 12'h010, 0, 0);
        step("seq5",      0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3044, 12'h011, 0, 0);
        step("misalign",  0, 0, 1, 32'h3002,      0, 0, 32'h0,         32'h0000_3002, 12'h000, 1, 0);
        step("last_word", 0, 0, 1, 32'h6FFC,      0, 0, 32'h0,         32'h0000_6FFC, 12'hFFF, 0, 0);
        step("above_im",  0, 0, 1, 32'h7000,      0, 0, 32'h0,         32'h0000_7000, 12'h000, 1, 0);
        step("below_im",  0, 0, 1, 32'h2FFC,      0, 0, 32'h0,         32'h0000_2FFC, 12'h000, 1, 0);
        step("top_addr",  0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 12'h000, 1, 0);
        step("wrap",      0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 12'h000, 1, 0);
        step("stall_rd4", 0, 1, 1, 32'h3100,      0, 0, 32'h0,         32'h0000_0000, 12'h000, 1, 1);
        step("rst_pend",  1, 1, 1, 32'h3200,      0, 0, 32'h0,         32'h0000_3000, 12'h000, 0, 0);
        step("post_rst",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 12'h001, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
